// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch/PC stage of the 16-bit datapath.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int          FETCH_WIDTH   = 16;
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;
    localparam logic [15:0] RESET_VEC_DEF = 16'h0000;
    localparam logic [15:0] PC_INC        = 16'd2;

endpackage

// File: rtl/fetch_pc_stage_if.sv
// Bundle between the fetch stage and its surroundings (next-PC mux, imem, hazard unit, decode).
interface fetch_pc_stage_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] instr_in;
    logic             stall;
    logic             flush;
    logic             halt_req;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_plus2;
    logic [WIDTH-1:0] ifid_instr;
    logic [WIDTH-1:0] ifid_pc2;
    logic             ifid_valid;
    logic             halted;

    modport master (
        output next_pc, instr_in, stall, flush, halt_req,
        input  pc_out, pc_plus2, ifid_instr, ifid_pc2, ifid_valid, halted
    );

    modport slave (
        input  next_pc, instr_in, stall, flush, halt_req,
        output pc_out, pc_plus2, ifid_instr, ifid_pc2, ifid_valid, halted
    );
endinterface

// File: rtl/fetch_pc_stage_pipe_reg16.sv
// Load-enabled register with asynchronous active-low clear to a parameter value.
module pipe_reg16 #(
    parameter int             WIDTH   = 16,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_pc_stage.sv
// PC register and IF/ID pipeline register with stall, flush and sticky halt.
//
// state | meaning
// BOOT  | one cycle after reset release; PC at reset vector, IF/ID empty
// RUN   | normal fetch; priority flush > stall > halt_req > advance
// HALT  | everything frozen until reset
module fetch_pc_stage
    import fetch_pkg::*;
#(
    parameter int               WIDTH     = FETCH_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(NOP_INSTR_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_pc_stage_if.slave io
);

    fetch_state_t     state;
    logic             run;
    logic             squash;
    logic             pc_en;
    logic             ifid_en;
    logic             valid_q;
    logic             halted_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] instr_d;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] pc2_d;
    logic [WIDTH-1:0] pc2_q;

    assign run     = (state == RUN);
    // Flush wins over stall; halt only squashes when not stalled.
    assign squash  = io.flush || (!io.stall && io.halt_req);
    assign pc_en   = run && (io.flush || (!io.stall && !io.halt_req));
    assign ifid_en = run && (io.flush || !io.stall);

    assign pc_inc  = pc_q + WIDTH'(PC_INC);
    assign pc_d    = {io.next_pc[WIDTH-1:1], 1'b0};
    assign instr_d = squash ? NOP_INSTR : io.instr_in;
    assign pc2_d   = squash ? '0 : pc_inc;

    pipe_reg16 #(.WIDTH(WIDTH), .CLR_VAL(RESET_VEC)) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_en),
        .d     (pc_d),
        .q     (pc_q)
    );

    pipe_reg16 #(.WIDTH(WIDTH), .CLR_VAL(NOP_INSTR)) u_ifid_instr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ifid_en),
        .d     (instr_d),
        .q     (instr_q)
    );

    pipe_reg16 #(.WIDTH(WIDTH), .CLR_VAL('0)) u_ifid_pc2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ifid_en),
        .d     (pc2_d),
        .q     (pc2_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (io.flush) begin
                        valid_q <= 1'b0;
                    end else if (io.stall) begin
                        valid_q <= valid_q;
                    end else if (io.halt_req) begin
                        valid_q  <= 1'b0;
                        halted_q <= 1'b1;
                        state    <= HALT;
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                HALT: state <= HALT;
                default: begin
                    state    <= BOOT;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign io.pc_out     = pc_q;
    assign io.pc_plus2   = pc_inc;
    assign io.ifid_instr = instr_q;
    assign io.ifid_pc2   = pc2_q;
    assign io.ifid_valid = valid_q;
    assign io.halted     = halted_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Randomized and directed checks of fetch_pc_stage against a behavioural model.
module tb_fetch_pc_stage;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;
    bit   loopback;
    int   halt_age;

    // behavioural model state
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_pc2;
    bit          m_valid;
    bit          m_halted;
    bit          m_booted;

    fetch_pc_stage_if #(.WIDTH(16)) bus ();

    fetch_pc_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one instruction-fetch step per edge, following the stage rules directly.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc     <= 16'h0000;
            m_instr  <= 16'h0000;
            m_pc2    <= 16'h0000;
            m_valid  <= 1'b0;
            m_halted <= 1'b0;
            m_booted <= 1'b0;
        end else if (!m_booted) begin
            m_booted <= 1'b1;
        end else if (!m_halted) begin
            if (bus.flush) begin
                m_pc    <= bus.next_pc & 16'hFFFE;
                m_instr <= 16'h0000;
                m_valid <= 1'b0;
            end else if (bus.stall) begin
                m_pc <= m_pc;
            end else if (bus.halt_req) begin
                m_instr  <= 16'h0000;
                m_valid  <= 1'b0;
                m_halted <= 1'b1;
            end else begin
                m_instr <= bus.instr_in;
                m_pc2   <= m_pc + 16'd2;
                m_pc    <= bus.next_pc & 16'hFFFE;
                m_valid <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("pc_out", bus.pc_out, m_pc);
        check("pc_plus2", bus.pc_plus2, m_pc + 16'd2);
        check("ifid_instr", bus.ifid_instr, m_instr);
        check("ifid_valid", {15'd0, bus.ifid_valid}, {15'd0, m_valid});
        check("halted", {15'd0, bus.halted}, {15'd0, m_halted});
        if (m_valid) check("ifid_pc2", bus.ifid_pc2, m_pc2);
    end

    task automatic tick();
        @(negedge clk);
        if (loopback) bus.next_pc = m_pc + 16'd2;
    endtask

    task automatic drive(input logic [15:0] npc, input bit st, input bit fl, input bit hr);
        loopback     = 1'b0;
        bus.next_pc  = npc;
        bus.stall    = st;
        bus.flush    = fl;
        bus.halt_req = hr;
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        halt_age = 0;
        rst_n = 1'b0;
        loopback = 1'b1;
        bus.next_pc = 16'h0002;
        bus.instr_in = 16'hA5A5;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.halt_req = 1'b0;

        // boot sequence with loopback
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("boot_pc", bus.pc_out, 16'h0000);
        check("boot_valid", {15'd0, bus.ifid_valid}, 16'h0000);
        tick();
        check("run1_pc", bus.pc_out, 16'h0002);
        check("run1_valid", {15'd0, bus.ifid_valid}, 16'h0001);
        check("run1_instr", bus.ifid_instr, 16'hA5A5);
        check("run1_pc2", bus.ifid_pc2, 16'h0002);
        bus.instr_in = 16'h0BAD;
        drive(16'h0010, 0, 0, 0);
        tick();
        check("jump_pc", bus.pc_out, 16'h0010);

        // three-cycle stall
        bus.instr_in = 16'h1234;
        drive(16'h0ABC, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", bus.pc_out, 16'h0010);
            check("stall_instr", bus.ifid_instr, 16'h0BAD);
            check("stall_pc2", bus.ifid_pc2, 16'h0004);
        end
        bus.stall = 1'b0;
        loopback = 1'b1;
        bus.next_pc = m_pc + 16'd2;
        tick();
        check("resume_pc", bus.pc_out, 16'h0012);
        check("resume_instr", bus.ifid_instr, 16'h1234);
        check("resume_pc2", bus.ifid_pc2, 16'h0012);

        // flush overrides stall
        drive(16'h0020, 0, 0, 0);
        tick();
        drive(16'h0100, 1, 1, 0);
        tick();
        check("flush_pc", bus.pc_out, 16'h0100);
        check("flush_instr", bus.ifid_instr, 16'h0000);
        check("flush_valid", {15'd0, bus.ifid_valid}, 16'h0000);

        // wraparound and alignment
        drive(16'hFFFE, 0, 0, 0);
        tick();
        check("wrap_pc", bus.pc_out, 16'hFFFE);
        check("wrap_plus2", bus.pc_plus2, 16'h0000);
        loopback = 1'b1;
        bus.next_pc = m_pc + 16'd2;
        tick();
        check("wrap_next", bus.pc_out, 16'h0000);
        drive(16'h0033, 0, 0, 0);
        tick();
        check("align_pc", bus.pc_out, 16'h0032);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.stall    = ($urandom_range(0, 3) == 0);
            bus.flush    = ($urandom_range(0, 7) == 0);
            bus.halt_req = ($urandom_range(0, 80) == 0);
            bus.instr_in = 16'($urandom);
            loopback     = ($urandom_range(0, 3) != 0);
            bus.next_pc  = loopback ? m_pc + 16'd2 : 16'($urandom);
            if (m_halted) halt_age++;
            if (halt_age > 5) begin
                rst_n = 1'b0;
                halt_age = 0;
            end else begin
                rst_n = 1'b1;
            end
            tick();
        end
        rst_n = 1'b1;

        // halt at 0x0040, then asynchronous reset mid-cycle
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(16'h0040, 0, 0, 0);
        tick();
        tick();
        check("pre_halt_pc", bus.pc_out, 16'h0040);
        drive(16'h0200, 0, 0, 1);
        tick();
        check("halt_flag", {15'd0, bus.halted}, 16'h0001);
        check("halt_valid", {15'd0, bus.ifid_valid}, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            bus.flush    = $urandom_range(0, 1) == 1;
            bus.stall    = $urandom_range(0, 1) == 1;
            bus.halt_req = $urandom_range(0, 1) == 1;
            bus.next_pc  = 16'($urandom);
            tick();
            check("halt_pc", bus.pc_out, 16'h0040);
            check("halt_sticky", {15'd0, bus.halted}, 16'h0001);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_pc", bus.pc_out, 16'h0000);
        check("arst_instr", bus.ifid_instr, 16'h0000);
        check("arst_pc2", bus.ifid_pc2, 16'h0000);
        check("arst_valid", {15'd0, bus.ifid_valid}, 16'h0000);
        check("arst_halted", {15'd0, bus.halted}, 16'h0000);
        check("arst_plus2", bus.pc_plus2, 16'h0002);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
